// File: rtl/hs_pkg.sv
// Shared definitions for the Muller handshake pipeline: protocol selectors,
// the C-element next-state function and the occupancy counter width.
package hs_pkg;

   localparam int HS_4PHASE = 0;
   localparam int HS_2PHASE = 1;

   // Generalised C-element: the output follows the inputs when they agree
   // and holds its previous value otherwise.
   function automatic logic hs_celem(input logic go, input logic ack_n, input logic q);
      return (go & ack_n) | (go & q) | (ack_n & q);
   endfunction

   // Width needed to count 0..depth held tokens.
   function automatic int hs_occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hs_stage.sv
// One pipeline stage: a C-element request register plus the bundled data
// register it latches on a request transition.
module hs_stage
   import hs_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PROTOCOL = HS_4PHASE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             ack,
   input  logic [WIDTH-1:0] d_in,
   output logic             req,
   output logic [WIDTH-1:0] d_out,
   output logic             full
);

   logic             req_q, req_d;
   logic [WIDTH-1:0] data_q;
   logic             cap;

   // Next request state and the data-capture strobe. A 4-phase token only
   // arrives on the rising request; in 2-phase every transition is a token.
   always_comb begin
      req_d = hs_celem(go, ~ack, req_q);
      if (PROTOCOL == HS_2PHASE) cap = req_d ^ req_q;
      else                       cap = req_d & ~req_q;
   end

   // Request and data registers; reset discards any held token.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q  <= 1'b0;
         data_q <= '0;
      end else begin
         req_q <= req_d;
         if (cap) data_q <= d_in;
      end
   end

   assign req   = req_q;
   assign d_out = data_q;
   // Token held: request raised but not yet acknowledged downstream.
   assign full  = (PROTOCOL == HS_2PHASE) ? (req_q ^ ack) : (req_q & ~ack);

endmodule

// File: rtl/hs_muller_pipe.sv
// N-stage Muller pipeline elastic buffer with bundled data, occupancy count
// and a sticky monitor for producer/consumer handshake violations.
// DEPTH must be even and at least 2; capacity is DEPTH/2 tokens.
module hs_muller_pipe
   import hs_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int PROTOCOL = HS_4PHASE
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        l_req,
   input  logic [WIDTH-1:0]            l_data,
   output logic                        l_ack,
   output logic                        r_req,
   output logic [WIDTH-1:0]            r_data,
   input  logic                        r_ack,
   output logic [DEPTH-1:0]            stage_full,
   output logic [hs_occ_w(DEPTH)-1:0]  occupancy,
   output logic                        protocol_err
);

   localparam int OCC_W = hs_occ_w(DEPTH);

   logic [DEPTH-1:0]            req, go, ack;
   logic [DEPTH-1:0][WIDTH-1:0] din, dq;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign go[i]  = l_req;
         assign din[i] = l_data;
      end else begin : g_mid
         assign go[i]  = req[i-1];
         assign din[i] = dq[i-1];
      end
      if (i == DEPTH-1) begin : g_last
         assign ack[i] = r_ack;
      end else begin : g_inner
         assign ack[i] = req[i+1];
      end

      hs_stage #(.WIDTH(WIDTH), .PROTOCOL(PROTOCOL)) u_stage (
         .clk  (clk),
         .rst  (rst),
         .go   (go[i]),
         .ack  (ack[i]),
         .d_in (din[i]),
         .req  (req[i]),
         .d_out(dq[i]),
         .full (stage_full[i])
      );
   end

   assign l_ack  = req[0];
   assign r_req  = req[DEPTH-1];
   assign r_data = dq[DEPTH-1];

   // Popcount of held tokens.
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(stage_full[i]);
   end

   logic lreq_q, rack_q, err_q, err_d;

   // An input edge is legal only if the handshake was pending in the cycle it
   // moved: the producer may toggle only when its last request is acked, the
   // consumer only when a request is outstanding (old ack differs from r_req).
   always_comb begin
      err_d = err_q;
      if ((l_req != lreq_q) && (lreq_q != l_ack)) err_d = 1'b1;
      if ((r_ack != rack_q) && (rack_q == r_req)) err_d = 1'b1;
   end

   // Previous-cycle environment inputs and the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lreq_q <= 1'b0;
         rack_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         lreq_q <= l_req;
         rack_q <= r_ack;
         err_q  <= err_d;
      end
   end

   assign protocol_err = err_q;

endmodule
